op_sequencer: RTL and testbench

//   Control FSM for the calculator datapath. Sequences one operation: operand A

---
 rtl/opseq_pkg.sv | 35 +++
 rtl/op_select_counter.sv | 29 ++
 rtl/op_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_op_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/opseq_pkg.sv
// Purpose : shared types and constants for the calculator operation sequencer.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package opseq_pkg;

    // FSM state encoding; the numeric values are visible on state_o.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_SEL_OP = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_EXEC   = 3'd4,
        ST_SHOW   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    // Operator codes as presented to the ALU on op_code.
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5
    } op_code_t;

    // Display pattern in ERROR. Held wide so any legal DATA_W can take a
    // low slice of it.
    localparam int                    DISP_W_MAX = 64;
    localparam logic [DISP_W_MAX-1:0] ERR_DISP   = {DISP_W_MAX{1'b1}};

    // EXEC wait counter width; covers the full timeout range 1..255.
    localparam int WAIT_W = 8;

endpackage

// File: rtl/op_select_counter.sv
// Purpose : operator-select counter, 0..NUM_OPS-1 with wrap.
// Latency : cnt updates on the clock edge where clr/adv are sampled.
// Backpressure: none; clr has priority over adv.
// Ports   : clock, rst (async, active-high), clr (sync clear), adv (step) -> cnt.
module op_select_counter
    import opseq_pkg::*;
#(
    parameter int NUM_OPS = 6
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    output logic [2:0] cnt
);

    localparam logic [2:0] CNT_LAST = 3'(NUM_OPS - 1);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cnt <= 3'd0;
        end else if (clr) begin
            cnt <= 3'd0;
        end else if (adv) begin
            cnt <= (cnt == CNT_LAST) ? 3'd0 : cnt + 3'd1;
        end
    end

endmodule

// File: rtl/op_sequencer.sv
// Purpose : control FSM for the calculator: operand A, operator, operand B, ALU handshake, result.
// Latency : button edges act one cycle after the registered rising edge; key_valid/alu_done act on the sampling edge.
// Backpressure: none; waits up to EXEC_TIMEOUT cycles for alu_done, then ERROR until a clear edge.
//
// Ports:
//   clock, rst                     clock and async active-high reset
//   key_valid, key_data[3:0]       hex digit strobe and value
//   op_btn, eq_btn, clr_btn        debounced button levels (rising edge counts)
//   alu_done, alu_result           ALU completion strobe and result
//   alu_start                      one-cycle start pulse, first EXEC cycle only
//   op_code                        operator-select counter
//   opnd_a, opnd_b                 operand registers
//   disp_val                       display value selected by state
//   state_o, busy, error           state encoding, EXEC flag, ERROR flag
//
// Build option: define OPSEQ_CHAIN_EN so an op edge in SHOW loads the result
// into operand A and goes back to operator selection.
module op_sequencer
    import opseq_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int NUM_OPS      = 6,
    parameter int EXEC_TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              key_valid,
    input  logic [3:0]        key_data,
    input  logic              op_btn,
    input  logic              eq_btn,
    input  logic              clr_btn,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              alu_start,
    output logic [2:0]        op_code,
    output logic [DATA_W-1:0] opnd_a,
    output logic [DATA_W-1:0] opnd_b,
    output logic [DATA_W-1:0] disp_val,
    output logic [2:0]        state_o,
    output logic              busy,
    output logic              error
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(EXEC_TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] opnd_a_nxt, opnd_b_nxt;
    logic [DATA_W-1:0] result_q, result_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic              cnt_clr, cnt_adv;

    // Buttons pass through two flops; an edge is d1 high with d2 still low,
    // so it is acted on one cycle after the button is first sampled high.
    // Bit order: {clr, eq, op}.
    logic [2:0] btn_d1, btn_d2, btn_edge;
    logic       op_edge, eq_edge, clr_edge;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            btn_d1 <= 3'b000;
            btn_d2 <= 3'b000;
        end else begin
            btn_d1 <= {clr_btn, eq_btn, op_btn};
            btn_d2 <= btn_d1;
        end
    end

    assign btn_edge = btn_d1 & ~btn_d2;
    assign op_edge  = btn_edge[0];
    assign eq_edge  = btn_edge[1];
    assign clr_edge = btn_edge[2];

    op_select_counter #(
        .NUM_OPS (NUM_OPS)
    ) u_op_cnt (
        .clock (clock),
        .rst   (rst),
        .clr   (cnt_clr),
        .adv   (cnt_adv),
        .cnt   (op_code)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            opnd_a   <= '0;
            opnd_b   <= '0;
            result_q <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            opnd_a   <= opnd_a_nxt;
            opnd_b   <= opnd_b_nxt;
            result_q <= result_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next state and register updates. Within a state only the events that
    // state responds to are considered, highest priority first:
    // clr > eq > op > key_valid (alu_done/timeout in EXEC).
    always_comb begin
        state_nxt  = state;
        opnd_a_nxt = opnd_a;
        opnd_b_nxt = opnd_b;
        result_nxt = result_q;
        wait_nxt   = wait_cnt;
        cnt_clr    = 1'b0;
        cnt_adv    = 1'b0;

        if (clr_edge) begin
            state_nxt  = ST_IDLE;
            opnd_a_nxt = '0;
            opnd_b_nxt = '0;
            result_nxt = '0;
            wait_nxt   = '0;
            cnt_clr    = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        opnd_a_nxt = {{(DATA_W-4){1'b0}}, key_data};
                        state_nxt  = ST_LOAD_A;
                    end
                end

                ST_LOAD_A: begin
                    if (op_edge) begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_SEL_OP;
                    end else if (key_valid) begin
                        opnd_a_nxt = {opnd_a[DATA_W-5:0], key_data};
                    end
                end

                ST_SEL_OP: begin
                    if (op_edge) begin
                        cnt_adv = 1'b1;
                    end else if (key_valid) begin
                        opnd_b_nxt = {{(DATA_W-4){1'b0}}, key_data};
                        state_nxt  = ST_LOAD_B;
                    end
                end

                ST_LOAD_B: begin
                    if (eq_edge) begin
                        wait_nxt  = '0;
                        state_nxt = ST_EXEC;
                    end else if (key_valid) begin
                        opnd_b_nxt = {opnd_b[DATA_W-5:0], key_data};
                    end
                end

                ST_EXEC: begin
                    // A done arriving in the last allowed cycle still wins.
                    if (alu_done) begin
                        result_nxt = alu_result;
                        state_nxt  = ST_SHOW;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_nxt = ST_ERROR;
                    end else begin
                        wait_nxt = wait_cnt + 1'b1;
                    end
                end

                ST_SHOW: begin
`ifdef OPSEQ_CHAIN_EN
                    if (op_edge) begin
                        opnd_a_nxt = result_q;
                        cnt_clr    = 1'b1;
                        state_nxt  = ST_SEL_OP;
                    end else
`endif
                    if (key_valid) begin
                        opnd_a_nxt = {{(DATA_W-4){1'b0}}, key_data};
                        state_nxt  = ST_LOAD_A;
                    end
                end

                ST_ERROR: begin
                    state_nxt = ST_ERROR;
                end

                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // wait_cnt is zeroed on entry to EXEC and steps every EXEC cycle, so it is
    // zero only in the first one; reset drops straight to IDLE, so an aborted
    // EXEC never pulses start again.
    assign alu_start = (state == ST_EXEC) && (wait_cnt == '0);

    always_comb begin
        disp_val = '0;
        case (state)
            ST_LOAD_A, ST_SEL_OP: disp_val = opnd_a;
            ST_LOAD_B, ST_EXEC:   disp_val = opnd_b;
            ST_SHOW:              disp_val = result_q;
            ST_ERROR:             disp_val = ERR_DISP[DATA_W-1:0];
            default:              disp_val = '0;
        endcase
    end

    assign state_o = state;
    assign busy    = (state == ST_EXEC);
    assign error   = (state == ST_ERROR);

endmodule

// File: tb/tb_op_sequencer.sv
// Purpose : directed self-checking bench for op_sequencer (default parameters).
// Latency : inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a; build with OPSEQ_CHAIN_EN defined to exercise chained operations.
module tb_op_sequencer;

    logic       clock = 1'b0;
    logic       rst;
    logic       key_valid;
    logic [3:0] key_data;
    logic       op_btn, eq_btn, clr_btn;
    logic       alu_done;
    logic [7:0] alu_result;
    logic       alu_start;
    logic [2:0] op_code;
    logic [7:0] opnd_a, opnd_b, disp_val;
    logic [2:0] state_o;
    logic       busy, error;

    int n_chk  = 0;
    int n_pass = 0;
    int start_cnt = 0;

    always #5 clock = ~clock;

    op_sequencer #(
        .DATA_W       (8),
        .NUM_OPS      (6),
        .EXEC_TIMEOUT (15)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_data   (key_data),
        .op_btn     (op_btn),
        .eq_btn     (eq_btn),
        .clr_btn    (clr_btn),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_start  (alu_start),
        .op_code    (op_code),
        .opnd_a     (opnd_a),
        .opnd_b     (opnd_b),
        .disp_val   (disp_val),
        .state_o    (state_o),
        .busy       (busy),
        .error      (error)
    );

    // Start pulses, counted on the rising edge that consumes them.
    always @(posedge clock) begin
        if (alu_start) start_cnt <= start_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_data  = d;
        tick();
        key_valid = 1'b0;
    endtask

    // m = {clr, eq, op}. Returns at the falling edge right after the FSM has
    // acted on the edge, with the buttons released.
    task automatic press(input logic [2:0] m);
        tick();
        op_btn  = m[0];
        eq_btn  = m[1];
        clr_btn = m[2];
        tick();
        tick();
        op_btn  = 1'b0;
        eq_btn  = 1'b0;
        clr_btn = 1'b0;
    endtask

    localparam logic [2:0] B_OP  = 3'b001;
    localparam logic [2:0] B_EQ  = 3'b010;
    localparam logic [2:0] B_CLR = 3'b100;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] wrap_seq [7];
        wrap_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};

        rst = 1'b1; key_valid = 1'b0; key_data = 4'h0;
        op_btn = 1'b0; eq_btn = 1'b0; clr_btn = 1'b0;
        alu_done = 1'b0; alu_result = 8'h00;
        repeat (3) tick();

        // Reset state
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_op_code", 32'(op_code), 32'd0);
        check("rst_disp", 32'(disp_val), 32'd0);
        check("rst_start", 32'(alu_start), 32'd0);
        check("rst_flags", 32'({busy, error}), 32'd0);
        rst = 1'b0;
        tick();

        // Full operation: 3,A op op op 5 eq, done with 0x0F in the third cycle
        key(4'h3);
        key(4'hA);
        check("a_3a", 32'(opnd_a), 32'h3A);
        check("disp_a", 32'(disp_val), 32'h3A);
        press(B_OP);
        check("sel_entry", 32'(state_o), 32'd2);
        press(B_OP);
        press(B_OP);
        check("op_code_2", 32'(op_code), 32'd2);
        key(4'h5);
        check("load_b", 32'(state_o), 32'd3);
        check("b_05", 32'(opnd_b), 32'h05);
        press(B_EQ);
        check("exec_state", 32'(state_o), 32'd4);
        check("exec_start1", 32'(alu_start), 32'd1);
        check("exec_busy", 32'(busy), 32'd1);
        tick();
        check("exec_start2", 32'(alu_start), 32'd0);
        tick();
        alu_done = 1'b1; alu_result = 8'h0F;
        tick();
        alu_done = 1'b0; alu_result = 8'h00;
        check("show_state", 32'(state_o), 32'd5);
        check("show_disp", 32'(disp_val), 32'h0F);
        check("start_cnt1", 32'(start_cnt), 32'd1);

        // Stray alu_done outside EXEC
        alu_done = 1'b1; alu_result = 8'h77;
        tick();
        alu_done = 1'b0;
        check("show_ign_done", 32'(disp_val), 32'h0F);

        // op in SHOW
        press(B_OP);
`ifdef OPSEQ_CHAIN_EN
        check("chain_state", 32'(state_o), 32'd2);
        check("chain_a", 32'(opnd_a), 32'h0F);
        check("chain_op_code", 32'(op_code), 32'd0);
`else
        check("nochain_state", 32'(state_o), 32'd5);
        check("nochain_disp", 32'(disp_val), 32'h0F);
`endif
        press(B_CLR);
        check("clr_idle", 32'(state_o), 32'd0);
        check("clr_regs", 32'({opnd_a, opnd_b}), 32'h0000);

        // Upper digits drop out; eq ignored in LOAD_A
        key(4'h1); key(4'h2); key(4'h3);
        check("a_shift", 32'(opnd_a), 32'h23);
        press(B_EQ);
        check("eq_ign_load_a", 32'(state_o), 32'd1);

        // Counter wrap
        press(B_OP);
        check("wrap_start", 32'(op_code), 32'd0);
        for (int i = 0; i < 7; i++) begin
            press(B_OP);
            check($sformatf("wrap_%0d", i), 32'(op_code), 32'(wrap_seq[i]));
        end
        press(B_EQ);
        check("eq_ign_sel", 32'(state_o), 32'd2);

        // Operand B, op ignored in LOAD_B, then timeout
        key(4'h9); key(4'h4);
        check("b_94", 32'(opnd_b), 32'h94);
        press(B_OP);
        check("op_ign_load_b", 32'(state_o), 32'd3);
        press(B_EQ);
        check("exec_disp_b", 32'(disp_val), 32'h94);
        repeat (14) tick();
        check("to_cycle15", 32'({state_o, error}), 32'({3'd4, 1'b0}));
        tick();
        check("to_error", 32'(error), 32'd1);
        check("to_state", 32'(state_o), 32'd6);
        check("to_disp", 32'(disp_val), 32'hFF);
        check("start_cnt2", 32'(start_cnt), 32'd2);
        key(4'h3);
        press(B_OP);
        check("err_hold", 32'(state_o), 32'd6);
        press(B_CLR);
        check("err_clr_state", 32'(state_o), 32'd0);
        check("err_clr_regs", 32'({opnd_a, opnd_b, 5'd0, op_code}), 32'd0);
        check("err_clr_disp", 32'(disp_val), 32'd0);

        // clr together with eq in LOAD_B
        key(4'h1);
        press(B_OP);
        key(4'h2);
        press(B_CLR | B_EQ);
        check("clr_eq_state", 32'(state_o), 32'd0);
        check("clr_eq_b", 32'(opnd_b), 32'd0);

        // op edge and key_valid in the same cycle in LOAD_A
        key(4'h4);
        tick();
        op_btn = 1'b1;
        tick();
        key_valid = 1'b1; key_data = 4'h9;
        tick();
        key_valid = 1'b0; op_btn = 1'b0;
        check("op_key_state", 32'(state_o), 32'd2);
        check("op_key_a", 32'(opnd_a), 32'h04);

        // Reset in the middle of EXEC
        key(4'h6);
        press(B_EQ);
        tick();
        rst = 1'b1;
        tick();
        check("rst_exec_state", 32'(state_o), 32'd0);
        check("rst_exec_start", 32'(alu_start), 32'd0);
        rst = 1'b0;
        repeat (5) tick();
        check("rst_exec_nostart", 32'(start_cnt), 32'd3);
        check("rst_exec_idle", 32'(state_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
